// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared encodings for the fetch hazard controller: PCSrc selects, FSM states, NOP word.
package fetch_hazard_ctrl_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;
    localparam logic [1:0] PCSRC_FOR = 2'b11;

    localparam logic [15:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_KILL     = 2'd3
    } state_e;

    // Redirect target select when several sources fire together: for > jump > branch.
    function automatic logic [1:0] redirect_pcsrc(input logic for_taken,
                                                  input logic jump,
                                                  input logic branch_taken);
        if (for_taken)         return PCSRC_FOR;
        else if (jump)         return PCSRC_JMP;
        else if (branch_taken) return PCSRC_BR;
        else                   return PCSRC_SEQ;
    endfunction

endpackage

// File: rtl/fetch_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID source that depends on the load now in EX.
module load_use_detect
    import fetch_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage sequencer: advance / stall / redirect-and-kill, plus stall and flush statistics.
// Statistics counters are built only when FETCH_HAZARD_STATS_EN is defined.
module fetch_hazard_ctrl
    import fetch_hazard_ctrl_pkg::*;
#(
    parameter int KILL_CYCLES = 1,
    parameter int REG_ADDR_W  = 3,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_busy,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_branch_taken,
    input  logic                  id_jump,
    input  logic                  id_for_taken,
    output logic [1:0]            PCSrc,
    output logic                  stall,
    output logic                  kill,
    output logic                  id_bubble,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    // kill_cnt counts the extra KILL cycles already spent; leave when it reaches this value.
    localparam logic [1:0] KILL_LAST = 2'(KILL_CYCLES - 2);

    state_e     state_q, state_d;
    logic [1:0] kill_cnt_q, kill_cnt_d;
    logic       load_use;
    logic       redirect;
    logic       accept;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .load_use    (load_use)
    );

    assign redirect = id_for_taken || id_jump || id_branch_taken;

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path infers a latch.
        state_d    = state_q;
        kill_cnt_d = kill_cnt_q;
        PCSrc      = PCSRC_SEQ;
        stall      = 1'b0;
        kill       = 1'b0;
        id_bubble  = 1'b0;
        accept     = 1'b0;

        if (rst_n) begin
            if (state_q == ST_KILL) begin
                // Wrong-path cycles: redirect inputs are ignored; a memory wait freezes the count.
                kill = 1'b1;
                if (mem_busy) begin
                    stall = 1'b1;
                end else if (kill_cnt_q == KILL_LAST) begin
                    state_d    = ST_RUN;
                    kill_cnt_d = 2'd0;
                end else begin
                    kill_cnt_d = kill_cnt_q + 2'd1;
                end
            end else if (mem_busy) begin
                stall   = 1'b1;
                state_d = ST_MEM_WAIT;
            end else if ((state_q != ST_LU_STALL) && load_use) begin
                stall     = 1'b1;
                id_bubble = 1'b1;
                state_d   = ST_LU_STALL;
            end else if (redirect) begin
                PCSrc      = redirect_pcsrc(id_for_taken, id_jump, id_branch_taken);
                kill       = 1'b1;
                accept     = 1'b1;
                kill_cnt_d = 2'd0;
                state_d    = (KILL_CYCLES > 1) ? ST_KILL : ST_RUN;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, not in the sensitivity list.
        if (!rst_n) begin
            state_q    <= ST_RUN;
            kill_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

`ifdef FETCH_HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Both counters wrap naturally at 2^CNT_W.
    always_comb begin
        stall_count_d = stall_count_q + CNT_W'(stall);
        flush_count_d = flush_count_q + CNT_W'(accept);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: directed scenarios on KILL_CYCLES=1 and =2 instances, then a random run vs a model.
module tb_fetch_hazard_ctrl;

`ifdef FETCH_HAZARD_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_busy, ex_mem_read;
    logic [2:0] ex_rd, id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic       id_branch_taken, id_jump, id_for_taken;

    logic [1:0]  pc1, pc2;
    logic        stall1, stall2, kill1, kill2, bub1, bub2;
    logic [15:0] sc1, sc2, fc1, fc2;
    logic [4:0]  vec1, vec2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign vec1 = {pc1, stall1, kill1, bub1};
    assign vec2 = {pc2, stall2, kill2, bub2};

    fetch_hazard_ctrl #(.KILL_CYCLES(1), .REG_ADDR_W(3), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_busy(mem_busy), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .id_for_taken(id_for_taken), .PCSrc(pc1), .stall(stall1), .kill(kill1),
        .id_bubble(bub1), .stall_count(sc1), .flush_count(fc1)
    );

    fetch_hazard_ctrl #(.KILL_CYCLES(2), .REG_ADDR_W(3), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_busy(mem_busy), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .id_for_taken(id_for_taken), .PCSrc(pc2), .stall(stall2), .kill(kill2),
        .id_bubble(bub2), .stall_count(sc2), .flush_count(fc2)
    );

    // Counter value the outputs should show, given whether statistics are built.
    function automatic logic [15:0] cexp(input int v);
        return STATS_EN ? 16'(v) : 16'd0;
    endfunction

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_busy = 0; ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_branch_taken = 0; id_jump = 0; id_for_taken = 0;
    endtask

    // Expected-vector layout in directed tests: {PCSrc[1:0], stall, kill, id_bubble}.
    task automatic test_reset();
        rst_n = 0; id_jump = 1;
        for (int c = 0; c < 2; c++) begin
            settle();
            tests_run++;
            if (vec1 !== 5'b00000 || vec2 !== 5'b00000) begin
                tests_failed++;
                $display("FAIL reset_outputs cyc%0d: got %b/%b want 00000", c, vec1, vec2);
            end
            tests_run++;
            if (sc1 !== 16'd0 || fc1 !== 16'd0 || sc2 !== 16'd0 || fc2 !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset_counters: got %0d %0d %0d %0d want 0", sc1, fc1, sc2, fc2);
            end
            advance();
        end
        rst_n = 1; clear_inputs();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_use_rs2 = 1;
        settle();
        tests_run++;
        if (vec1 !== 5'b00101 || vec2 !== 5'b00101) begin
            tests_failed++;
            $display("FAIL lu_stall: got %b/%b want 00101", vec1, vec2);
        end
        advance();
        settle();
        tests_run++;
        if (vec1 !== 5'b00000 || vec2 !== 5'b00000) begin
            tests_failed++;
            $display("FAIL lu_release: got %b/%b want 00000", vec1, vec2);
        end
        tests_run++;
        if (sc1 !== cexp(1) || sc2 !== cexp(1)) begin
            tests_failed++;
            $display("FAIL lu_stall_count: got %0d/%0d want %0d", sc1, sc2, cexp(1));
        end
        advance();
        clear_inputs();
        settle();
        advance();
    endtask

    task automatic test_for_jump();
        id_for_taken = 1; id_jump = 1;
        settle();
        tests_run++;
        if (vec1 !== 5'b11010 || vec2 !== 5'b11010) begin
            tests_failed++;
            $display("FAIL for_over_jump: got %b/%b want 11010", vec1, vec2);
        end
        advance();
        clear_inputs();
        settle();
        tests_run++;
        if (vec1 !== 5'b00000 || vec2 !== 5'b00010) begin
            tests_failed++;
            $display("FAIL for_kill_len: got %b/%b want 00000/00010", vec1, vec2);
        end
        tests_run++;
        if (fc1 !== cexp(1) || fc2 !== cexp(1)) begin
            tests_failed++;
            $display("FAIL for_flush_count: got %0d/%0d want %0d", fc1, fc2, cexp(1));
        end
        advance();
        settle();
        tests_run++;
        if (vec2 !== 5'b00000) begin
            tests_failed++;
            $display("FAIL for_kill2_end: got %b want 00000", vec2);
        end
        advance();
    endtask

    task automatic test_kill2();
        id_branch_taken = 1;
        settle();
        tests_run++;
        if (vec2 !== 5'b01010) begin
            tests_failed++;
            $display("FAIL k2_branch: got %b want 01010", vec2);
        end
        advance();
        id_branch_taken = 0; id_jump = 1;
        settle();
        tests_run++;
        if (vec2 !== 5'b00010 || vec1 !== 5'b10010) begin
            tests_failed++;
            $display("FAIL k2_jump_ignored: got %b/%b want 00010/10010", vec2, vec1);
        end
        advance();
        clear_inputs();
        settle();
        tests_run++;
        if (vec2 !== 5'b00000 || fc2 !== cexp(2) || fc1 !== cexp(3)) begin
            tests_failed++;
            $display("FAIL k2_done: got %b fc2=%0d fc1=%0d want 00000 %0d %0d",
                     vec2, fc2, fc1, cexp(2), cexp(3));
        end
        advance();
    endtask

    task automatic test_mem_wait();
        mem_busy = 1; id_jump = 1;
        for (int c = 0; c < 3; c++) begin
            settle();
            tests_run++;
            if (vec1 !== 5'b00100 || vec2 !== 5'b00100) begin
                tests_failed++;
                $display("FAIL mem_hold cyc%0d: got %b/%b want 00100", c, vec1, vec2);
            end
            advance();
        end
        mem_busy = 0;
        settle();
        tests_run++;
        if (vec1 !== 5'b10010 || vec2 !== 5'b10010) begin
            tests_failed++;
            $display("FAIL mem_release_jump: got %b/%b want 10010", vec1, vec2);
        end
        tests_run++;
        if (sc1 !== cexp(4) || sc2 !== cexp(4)) begin
            tests_failed++;
            $display("FAIL mem_stall_count: got %0d/%0d want %0d", sc1, sc2, cexp(4));
        end
        advance();
        clear_inputs();
        settle();
        advance();
    endtask

    task automatic test_lu_branch();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_branch_taken = 1;
        settle();
        tests_run++;
        if (vec1 !== 5'b00101 || vec2 !== 5'b00101) begin
            tests_failed++;
            $display("FAIL lub_stall: got %b/%b want 00101", vec1, vec2);
        end
        advance();
        settle();
        tests_run++;
        if (vec1 !== 5'b01010 || vec2 !== 5'b01010) begin
            tests_failed++;
            $display("FAIL lub_deferred_branch: got %b/%b want 01010", vec1, vec2);
        end
        advance();
        clear_inputs();
        settle();
        tests_run++;
        if (fc1 !== cexp(5) || sc1 !== cexp(5)) begin
            tests_failed++;
            $display("FAIL lub_counts: got fc=%0d sc=%0d want %0d %0d", fc1, sc1, cexp(5), cexp(5));
        end
        advance();
    endtask

    task automatic test_kill_mem();
        id_jump = 1;
        settle();
        advance();
        id_jump = 0; mem_busy = 1;
        for (int c = 0; c < 2; c++) begin
            settle();
            tests_run++;
            if (vec2 !== 5'b00110 || vec1 !== 5'b00100) begin
                tests_failed++;
                $display("FAIL kill_mem_hold cyc%0d: got %b/%b want 00110/00100", c, vec2, vec1);
            end
            advance();
        end
        mem_busy = 0;
        settle();
        tests_run++;
        if (vec2 !== 5'b00010 || vec1 !== 5'b00000) begin
            tests_failed++;
            $display("FAIL kill_mem_resume: got %b/%b want 00010/00000", vec2, vec1);
        end
        advance();
        settle();
        tests_run++;
        if (vec2 !== 5'b00000 || sc2 !== cexp(7) || sc1 !== cexp(7)) begin
            tests_failed++;
            $display("FAIL kill_mem_end: got %b sc=%0d/%0d want 00000 %0d", vec2, sc1, sc2, cexp(7));
        end
        advance();
    endtask

    task automatic test_no_hazard();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 1; id_use_rs2 = 1;
        settle();
        tests_run++;
        if (vec1 !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reg0_no_hazard: got %b want 00000", vec1);
        end
        advance();
        ex_rd = 2; id_rs1 = 2; id_use_rs1 = 0; id_use_rs2 = 0;
        settle();
        tests_run++;
        if (vec1 !== 5'b00000) begin
            tests_failed++;
            $display("FAIL unused_src_no_hazard: got %b want 00000", vec1);
        end
        advance();
        clear_inputs();
    endtask

    // Reference model: per instance, remaining extra kill cycles, whether last cycle was a
    // load-use stall, and running counts.
    int          m_kill_left [2];
    bit          m_lu_prev   [2];
    int          m_stalls    [2];
    int          m_flushes   [2];
    bit          cnt_known;

    function automatic bit model_hazard();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    task automatic test_random();
        logic [4:0]  exp_vec [2];
        logic [15:0] exp_sc  [2];
        logic [15:0] exp_fc  [2];
        logic [4:0]  got_vec;
        logic [15:0] got_sc, got_fc;
        cnt_known = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst_n           = (cyc == 0) ? 1'b0 : ($urandom_range(49) != 0);
            mem_busy        = ($urandom_range(4) == 0);
            ex_mem_read     = $urandom_range(1);
            ex_rd           = 3'($urandom_range(3));
            id_rs1          = 3'($urandom_range(3));
            id_rs2          = 3'($urandom_range(3));
            id_use_rs1      = $urandom_range(1);
            id_use_rs2      = $urandom_range(1);
            id_branch_taken = ($urandom_range(5) == 0);
            id_jump         = ($urandom_range(5) == 0);
            id_for_taken    = ($urandom_range(5) == 0);
            settle();
            for (int i = 0; i < 2; i++) begin
                logic [1:0] pc;
                bit st, ko, bb;
                pc = 0; st = 0; ko = 0; bb = 0;
                exp_sc[i] = cexp(m_stalls[i]);
                exp_fc[i] = cexp(m_flushes[i]);
                if (!rst_n) begin
                    m_kill_left[i] = 0; m_lu_prev[i] = 0;
                end else if (m_kill_left[i] > 0) begin
                    ko = 1; st = mem_busy;
                    if (!mem_busy) m_kill_left[i]--;
                    m_lu_prev[i] = 0;
                end else if (mem_busy) begin
                    st = 1; m_lu_prev[i] = 0;
                end else if (!m_lu_prev[i] && model_hazard()) begin
                    st = 1; bb = 1; m_lu_prev[i] = 1;
                end else begin
                    m_lu_prev[i] = 0;
                    if (id_for_taken || id_jump || id_branch_taken) begin
                        pc = id_for_taken ? 2'd3 : (id_jump ? 2'd2 : 2'd1);
                        ko = 1;
                        m_kill_left[i] = i;  // instance i has KILL_CYCLES = i+1
                        m_flushes[i] = (m_flushes[i] + 1) % 65536;
                    end
                end
                if (st) m_stalls[i] = (m_stalls[i] + 1) % 65536;
                if (!rst_n) begin
                    m_stalls[i] = 0; m_flushes[i] = 0;
                end
                exp_vec[i] = {pc, st, ko, bb};
            end
            for (int i = 0; i < 2; i++) begin
                got_vec = (i == 0) ? vec1 : vec2;
                got_sc  = (i == 0) ? sc1 : sc2;
                got_fc  = (i == 0) ? fc1 : fc2;
                tests_run++;
                if (got_vec !== exp_vec[i]) begin
                    tests_failed++;
                    $display("FAIL rand_ctrl k%0d cyc%0d: got %b want %b", i + 1, cyc, got_vec, exp_vec[i]);
                end
                if (cnt_known) begin
                    tests_run++;
                    if (got_sc !== exp_sc[i] || got_fc !== exp_fc[i]) begin
                        tests_failed++;
                        $display("FAIL rand_counts k%0d cyc%0d: got %0d/%0d want %0d/%0d",
                                 i + 1, cyc, got_sc, got_fc, exp_sc[i], exp_fc[i]);
                    end
                end
            end
            if (!rst_n) cnt_known = 1;
            advance();
        end
        rst_n = 1; clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_kill_left[i] = 0; m_lu_prev[i] = 0; m_stalls[i] = 0; m_flushes[i] = 0;
        end
        advance();
        test_reset();
        test_load_use();
        test_for_jump();
        test_kill2();
        test_mem_wait();
        test_lu_branch();
        test_kill_mem();
        test_no_hazard();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
